rr_grant_ctrl: RTL and testbench



---
 rtl/rr_grant_ctrl_if.sv | 21 ++
 rtl/rr_grant_ctrl.sv | 108 ++++++++++
 tb/tb_rr_grant_ctrl.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_grant_ctrl_if.sv
// rtl/rr_grant_ctrl_if.sv - request/grant bundle between the requester bank and the round-robin arbiter
//
// Signals:
//   req       [7:0]  request vector, bit i = requester i
//   gnt       [7:0]  one-hot grant, zero when no grant is active
//   gnt_id    [2:0]  index of the current or last granted requester
//   gnt_valid        high while gnt is non-zero
//   timeout          one-cycle pulse when a grant is revoked by hold expiry
// Modports:
//   master  requester side (drives req)
//   slave   arbiter side (drives grant outputs)
interface rr_grant_ctrl_if;
   logic [7:0] req;
   logic [7:0] gnt;
   logic [2:0] gnt_id;
   logic       gnt_valid;
   logic       timeout;

   modport master (output req, input gnt, input gnt_id, input gnt_valid, input timeout);
   modport slave  (input req, output gnt, output gnt_id, output gnt_valid, output timeout);
endinterface

// File: rtl/rr_grant_ctrl.sv
// rtl/rr_grant_ctrl.sv - 8-way round-robin arbiter with grant hold limit and idle gap
//
// Purpose:
//   Shares one resource among 8 requesters. The winner is the first requester
//   at or after (last_id+1) mod 8; the grant is held while the owner keeps its
//   request, up to MAX_HOLD cycles, followed by one mandatory GAP cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    rr_grant_ctrl_if.slave: req in; gnt, gnt_id, gnt_valid, timeout out
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles (1..255)
module rr_grant_ctrl #(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   rr_grant_ctrl_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GRANT = 2'd1,
      S_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

   state_t     r_state;
   logic [7:0] r_gnt;
   logic [2:0] r_gnt_id;
   logic       r_gnt_valid;
   logic       r_timeout;
   logic [2:0] r_last_id;
   logic [7:0] r_hold_cnt;

   logic [2:0] w_winner;
   logic [2:0] w_scan_idx;

   // Scan from the farthest offset down to the nearest, so the nearest set bit
   // after last_id is the one left in w_winner.
   always_comb begin
      w_winner   = r_last_id + 3'd1;
      w_scan_idx = r_last_id + 3'd1;
      for (int k = 7; k >= 0; k--) begin
         w_scan_idx = r_last_id + 3'd1 + 3'(k);
         if (bus.req[w_scan_idx]) begin
            w_winner = w_scan_idx;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_gnt       <= 8'h00;
         r_gnt_id    <= 3'd0;
         r_gnt_valid <= 1'b0;
         r_timeout   <= 1'b0;
         r_last_id   <= 3'd7;
         r_hold_cnt  <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               r_timeout <= 1'b0;
               if (|bus.req) begin
                  r_gnt       <= 8'b1 << w_winner;
                  r_gnt_id    <= w_winner;
                  r_gnt_valid <= 1'b1;
                  r_last_id   <= w_winner;
                  r_hold_cnt  <= 8'd0;
                  r_state     <= S_GRANT;
               end
            end
            S_GRANT: begin
               // A dropped request takes priority over hold expiry: no timeout.
               if (!bus.req[r_gnt_id]) begin
                  r_gnt       <= 8'h00;
                  r_gnt_valid <= 1'b0;
                  r_timeout   <= 1'b0;
                  r_state     <= S_GAP;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  r_gnt       <= 8'h00;
                  r_gnt_valid <= 1'b0;
                  r_timeout   <= 1'b1;
                  r_state     <= S_GAP;
               end else begin
                  r_hold_cnt  <= r_hold_cnt + 8'd1;
               end
            end
            S_GAP: begin
               r_timeout <= 1'b0;
               r_state   <= S_IDLE;
            end
            default: begin
               r_timeout <= 1'b0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.gnt       = r_gnt;
   assign bus.gnt_id    = r_gnt_id;
   assign bus.gnt_valid = r_gnt_valid;
   assign bus.timeout   = r_timeout;

endmodule

// File: tb/tb_rr_grant_ctrl.sv
// tb/tb_rr_grant_ctrl.sv - self-checking bench for rr_grant_ctrl (MAX_HOLD 16 and 1)
module tb_rr_grant_ctrl;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [7:0] req;

   always #5 clk = ~clk;

   rr_grant_ctrl_if u_if16 ();
   rr_grant_ctrl_if u_if1 ();

   assign u_if16.req = req;
   assign u_if1.req  = req;

   rr_grant_ctrl #(.MAX_HOLD(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(u_if16));
   rr_grant_ctrl #(.MAX_HOLD(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(u_if1));

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model, one slot per DUT instance.
   int m_owner [2];   // granted requester, -1 when none
   int m_held  [2];   // clock edges seen while the grant was active
   int m_gap   [2];   // dead cycles still owed before arbitration
   int m_last  [2];
   int m_id    [2];
   bit m_to    [2];
   int m_lim   [2] = '{16, 1};

   int q_ids[$];
   logic [7:0] h_gnt [40];
   logic       h_to  [40];

   function automatic void model_reset();
      for (int i = 0; i < 2; i++) begin
         m_owner[i] = -1;
         m_held[i]  = 0;
         m_gap[i]   = 0;
         m_last[i]  = 7;
         m_id[i]    = 0;
         m_to[i]    = 1'b0;
      end
   endfunction

   function automatic void model_step(input logic [7:0] r);
      for (int i = 0; i < 2; i++) begin
         m_to[i] = 1'b0;
         if (m_owner[i] >= 0) begin
            m_held[i]++;
            if (!r[m_owner[i]]) begin
               m_owner[i] = -1;
               m_gap[i]   = 1;
            end else if (m_held[i] >= m_lim[i]) begin
               m_owner[i] = -1;
               m_gap[i]   = 1;
               m_to[i]    = 1'b1;
            end
         end else if (m_gap[i] > 0) begin
            m_gap[i]--;
         end else if (r != 8'h00) begin
            for (int off = 1; off <= 8; off++) begin
               int c;
               c = (m_last[i] + off) % 8;
               if (r[c]) begin
                  m_owner[i] = c;
                  m_held[i]  = 0;
                  m_last[i]  = c;
                  m_id[i]    = c;
                  break;
               end
            end
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [7:0] g;
      logic [2:0] id;
      logic       v;
      logic       t;
      logic [7:0] eg;
      for (int i = 0; i < 2; i++) begin
         if (i == 0) begin
            g = u_if16.gnt; id = u_if16.gnt_id; v = u_if16.gnt_valid; t = u_if16.timeout;
         end else begin
            g = u_if1.gnt;  id = u_if1.gnt_id;  v = u_if1.gnt_valid;  t = u_if1.timeout;
         end
         eg = (m_owner[i] >= 0) ? 8'(1 << m_owner[i]) : 8'h00;
         chk($sformatf("gnt[%0d]", i), g, eg);
         chk($sformatf("gnt_id[%0d]", i), {5'b0, id}, 8'(m_id[i]));
         chk($sformatf("gnt_valid[%0d]", i), {7'b0, v}, {7'b0, (m_owner[i] >= 0)});
         chk($sformatf("timeout[%0d]", i), {7'b0, t}, {7'b0, m_to[i]});
         chk($sformatf("onehot0[%0d]", i), {7'b0, $onehot0(g)}, 8'h01);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(req);
      @(negedge clk);
      check_all();
   endtask

   task automatic drain();
      req = 8'h00;
      repeat (4) tick();
   endtask

   function automatic int qat(input int k);
      return (k < q_ids.size()) ? q_ids[k] : 99;
   endfunction

   initial begin
      int   s;
      int   len;
      int   k;
      logic prev_v;

      // Reset with all requesters asserting.
      rst_n = 1'b0;
      req   = 8'hFF;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_gnt16", u_if16.gnt, 8'h00);
      chk("reset_gnt1", u_if1.gnt, 8'h00);
      check_all();
      rst_n = 1'b1;
      tick();
      chk("first_gnt", u_if16.gnt, 8'h01);
      chk("first_id", {5'b0, u_if16.gnt_id}, 8'h00);
      drain();

      // Round-robin: each owner drops its request after 3 granted cycles.
      q_ids.delete();
      prev_v = 1'b0;
      for (int c = 0; c < 60; c++) begin
         req = 8'hA4;
         if (m_owner[0] >= 0 && m_held[0] >= 2) req[m_owner[0]] = 1'b0;
         tick();
         if (u_if16.gnt_valid && !prev_v) q_ids.push_back(int'(u_if16.gnt_id));
         prev_v = u_if16.gnt_valid;
      end
      chk("rr_seq0", 8'(qat(0)), 8'd2);
      chk("rr_seq1", 8'(qat(1)), 8'd5);
      chk("rr_seq2", 8'(qat(2)), 8'd7);
      chk("rr_seq3", 8'(qat(3)), 8'd2);
      drain();

      // Wrap-around from last_id = 6.
      req = 8'h40;
      k = 0;
      while (m_owner[0] != 6 && k < 20) begin tick(); k++; end
      chk("wrap_setup", u_if16.gnt, 8'h40);
      drain();
      req = 8'h03;
      q_ids.delete();
      prev_v = 1'b0;
      for (int c = 0; c < 40; c++) begin
         tick();
         if (u_if16.gnt_valid && !prev_v) q_ids.push_back(int'(u_if16.gnt_id));
         prev_v = u_if16.gnt_valid;
      end
      chk("wrap_first", 8'(qat(0)), 8'd0);
      chk("wrap_second", 8'(qat(1)), 8'd1);
      drain();

      // Hold timeout with a single continuous requester.
      req = 8'h08;
      for (int c = 0; c < 40; c++) begin
         tick();
         h_gnt[c] = u_if16.gnt;
         h_to[c]  = u_if16.timeout;
      end
      s = -1;
      for (int c = 39; c >= 0; c--) if (h_gnt[c] == 8'h08) s = c;
      len = 0;
      if (s >= 0) while (s + len < 40 && h_gnt[s + len] == 8'h08) len++;
      chk("to_found", {7'b0, (s >= 0)}, 8'h01);
      if (s >= 0 && s + len + 2 < 40) begin
         chk("to_len", 8'(len), 8'd16);
         chk("to_pulse", {7'b0, h_to[s + len]}, 8'h01);
         chk("to_gap0", h_gnt[s + len], 8'h00);
         chk("to_gap1", h_gnt[s + len + 1], 8'h00);
         chk("to_pulse_clr", {7'b0, h_to[s + len + 1]}, 8'h00);
         chk("to_regrant", h_gnt[s + len + 2], 8'h08);
      end
      drain();

      // Release in the same cycle the hold limit would expire.
      req = 8'h10;
      k = 0;
      while (m_owner[0] != 4 && k < 20) begin tick(); k++; end
      k = 0;
      while (m_held[0] < 15 && k < 20) begin tick(); k++; end
      chk("rel_last_cycle", u_if16.gnt, 8'h10);
      req = 8'h00;
      tick();
      chk("rel_no_timeout", {7'b0, u_if16.timeout}, 8'h00);
      chk("rel_gnt_off", u_if16.gnt, 8'h00);
      drain();

      // Asynchronous reset in the middle of a grant.
      req = 8'h20;
      k = 0;
      while (m_owner[0] != 5 && k < 20) begin tick(); k++; end
      tick();
      chk("ar_pre", u_if16.gnt, 8'h20);
      #2;
      rst_n = 1'b0;
      req   = 8'hFF;
      #1;
      chk("ar_gnt", u_if16.gnt, 8'h00);
      chk("ar_valid", {7'b0, u_if16.gnt_valid}, 8'h00);
      chk("ar_timeout", {7'b0, u_if16.timeout}, 8'h00);
      chk("ar_id", {5'b0, u_if16.gnt_id}, 8'h00);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      chk("ar_first_gnt", u_if16.gnt, 8'h01);
      drain();

      // Randomized traffic against the model.
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 3) == 0) begin
            if ($urandom_range(0, 1) == 0) req = 8'($urandom);
            else req = 8'($urandom & $urandom & $urandom);
         end
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
